if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage upstream of the decode/immediate-generation logic. Owns the PC,
//  issues one-outstanding requests to instruction memory, and holds the fetched word with its PC
//  on a valid/ready interface to decode. Accepts PC redirects (branch/JAL/JALR targets computed
//  downstream from the I/S/B/U/J immediates) and squashes any wrong-path fetch.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NOP_INST   32'h0000_0013  id_inst value when nothing valid is held (addi x0,x0,0)
// PORTS
//  clk              in   1   clock, rising edge
//  rst_n            in   1   reset, asynchronous assert, active-low
//  imem_req         out  1   fetch request; held high until imem_gnt
//  imem_addr        out  32  fetch address = pc; stable while imem_req=1
//  imem_gnt         in   1   request accepted this cycle
//  imem_rvalid      in   1   read data valid (>=1 cycle after gnt, in order)
//  imem_rdata       in   32  instruction word
//  redirect_valid   in   1   one-cycle pulse: replace PC with redirect_target
//  redirect_target  in   32  new PC
//  id_ready         in   1   decode accepts id_* this cycle
//  id_valid         out  1   id_inst/id_pc/id_pc4 valid
//  id_inst          out  32  fetched instruction
//  id_pc            out  32  address of id_inst
//  id_pc4           out  32  id_pc + 4 (link value)
//  fetch_misalign   out  1   only with IF_MISALIGN_TRAP_EN; tied 0 otherwise
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, imem_req=0, id_valid=0, id_inst=NOP_INST,
//   id_pc=RESET_PC, id_pc4=RESET_PC+4, kill=0, fetch_misalign=0.
//  FSM (registered outputs only):
//   IDLE : one cycle after reset release -> REQ.
//   REQ  : imem_req=1, imem_addr=pc. gnt -> WAIT.
//   WAIT : wait imem_rvalid. rvalid & !kill -> FULL; capture id_inst=rdata, id_pc=pc,
//          id_pc4=pc+4, pc<=pc+4, id_valid=1. rvalid & kill -> REQ, kill<=0, data dropped.
//   FULL : id_valid=1, id_* held stable. id_ready -> REQ, id_valid<=0, id_inst<=NOP_INST.
//  Redirect (any state, highest priority, same edge):
//   pc<=redirect_target; id_valid<=0; id_inst<=NOP_INST.
//   REQ & !gnt: stay REQ, new address next cycle. REQ & gnt: -> WAIT with kill<=1.
//   WAIT: kill<=1, stay WAIT (unless rvalid same cycle: drop data, -> REQ, kill<=0).
//   FULL: -> REQ; held word discarded even if id_ready same cycle. IDLE: -> REQ.
//  Throughput: zero-wait memory (gnt in REQ cycle, rvalid next) gives one instruction per
//   3 cycles; at most one outstanding request, never a second req while in WAIT.
//  Arithmetic: pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0 without error.
//  rvalid outside WAIT is ignored (protocol violation; flagged by assertion).
// CONFIGURATION
//  IF_MISALIGN_TRAP_EN defined: redirect_target[1:0]!=0 -> state TRAP: imem_req=0,
//   id_valid=0, fetch_misalign=1, pc=target; leaves only on an aligned redirect (-> REQ,
//   fetch_misalign<=0). Pending WAIT response first drained via kill before TRAP is visible
//   on imem side (no req issued meanwhile). Undefined: target[1:0] forced to 2'b00, no TRAP,
//   fetch_misalign tied 0.
// STRUCTURE
//  Shared package/header: FSM state encoding (IDLE, REQ, WAIT, FULL, TRAP), NOP_INST constant,
//   XLEN=32. Single flat module; the PC register + next-PC mux can be split as if_pc_reg if
//   reused by the pipelined core.
// TESTING
//  1 Reset: rst_n low mid-WAIT -> all outputs to reset values immediately; first imem_addr=0.
//  2 Sequential: zero-wait memory returning 0x00500093,0x00100113 -> id_pc 0,4 with id_inst
//    matching, id_pc4 4,8, one instruction per 3 cycles, id_ready held 1.
//  3 Backpressure: id_ready=0 for 5 cycles in FULL -> id_* stable, imem_req=0, no new fetch.
//  4 Redirect in WAIT to 0x100: stale rdata dropped, next imem_addr=0x100, id_pc=0x100.
//  5 Redirect + id_ready same cycle in FULL -> held word discarded, next id_pc = target.
//  6 Misalign 0x102: with IF_MISALIGN_TRAP_EN fetch_misalign=1, no req until redirect 0x200;
//    without it next imem_addr=0x100. PC wrap: 0xFFFFFFFC -> next addr 0.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath width, NOP encoding, FSM states.
package if_fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] IF_NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_FULL = 3'd3,
    ST_TRAP = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Bundle of the fetch stage's instruction-memory, redirect and decode-side signals.
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;

  logic            id_ready;
  logic            id_valid;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc4;
  logic            fetch_misalign;

  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pc, id_pc4, fetch_misalign,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_target, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_inst, id_pc, id_pc4, fetch_misalign,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_target, id_ready
  );

endinterface

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter with redirect load (priority) and sequential +4 advance, wrapping mod 2^32.
module if_fetch_stage_pc_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4
);

  assign pc4 = pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (advance) begin
      pc <= pc4;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: one outstanding imem request, holds fetched word for decode, squashes on redirect.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = IF_NOP_INST
) (
  input  logic              clk,
  input  logic              rst_n,
  if_fetch_stage_if.master  bus
);

  fetch_state_e    state, state_nxt;
  logic            kill, kill_nxt;
  logic            trap_pend, trap_pend_nxt;
  logic            capture;
  logic            drop_id;
  logic [XLEN-1:0] pc, pc4;
  logic [XLEN-1:0] redir_pc;
  logic            redir_misalign;
  logic [XLEN-1:0] id_inst_q, id_pc_q, id_pc4_q;

`ifdef IF_MISALIGN_TRAP_EN
  assign redir_pc       = bus.redirect_target;
  assign redir_misalign = (bus.redirect_target[1:0] != 2'b00);
`else
  logic unused_target_lo;
  assign unused_target_lo = ^bus.redirect_target[1:0];
  assign redir_pc         = {bus.redirect_target[XLEN-1:2], 2'b00};
  assign redir_misalign   = 1'b0;
`endif

  if_fetch_stage_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (bus.redirect_valid),
    .load_pc (redir_pc),
    .advance (capture),
    .pc      (pc),
    .pc4     (pc4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      kill      <= 1'b0;
      trap_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      kill      <= kill_nxt;
      trap_pend <= trap_pend_nxt;
    end
  end

  // A redirect outranks every other event; a misaligned target still drains an in-flight response first.
  always_comb begin
    state_nxt     = state;
    kill_nxt      = kill;
    trap_pend_nxt = trap_pend;
    capture       = 1'b0;
    drop_id       = 1'b0;
    if (bus.redirect_valid) begin
      drop_id       = 1'b1;
      trap_pend_nxt = 1'b0;
      case (state)
        ST_REQ: begin
          if (bus.imem_gnt) begin
            state_nxt     = ST_WAIT;
            kill_nxt      = 1'b1;
            trap_pend_nxt = redir_misalign;
          end else begin
            state_nxt = redir_misalign ? ST_TRAP : ST_REQ;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            kill_nxt  = 1'b0;
            state_nxt = redir_misalign ? ST_TRAP : ST_REQ;
          end else begin
            kill_nxt      = 1'b1;
            trap_pend_nxt = redir_misalign;
          end
        end
        default: state_nxt = redir_misalign ? ST_TRAP : ST_REQ;
      endcase
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_REQ;
        ST_REQ: begin
          if (bus.imem_gnt) state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            if (kill) begin
              kill_nxt      = 1'b0;
              trap_pend_nxt = 1'b0;
              state_nxt     = trap_pend ? ST_TRAP : ST_REQ;
            end else begin
              capture   = 1'b1;
              state_nxt = ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (bus.id_ready) begin
            drop_id   = 1'b1;
            state_nxt = ST_REQ;
          end
        end
        ST_TRAP: state_nxt = ST_TRAP;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_inst_q <= NOP_INST;
      id_pc_q   <= RESET_PC;
      id_pc4_q  <= RESET_PC + 32'd4;
    end else if (capture) begin
      id_inst_q <= bus.imem_rdata;
      id_pc_q   <= pc;
      id_pc4_q  <= pc4;
    end else if (drop_id) begin
      id_inst_q <= NOP_INST;
    end
  end

  assign bus.imem_req  = (state == ST_REQ);
  assign bus.imem_addr = pc;
  assign bus.id_valid  = (state == ST_FULL);
  assign bus.id_inst   = id_inst_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_pc4    = id_pc4_q;

`ifdef IF_MISALIGN_TRAP_EN
  assign bus.fetch_misalign = (state == ST_TRAP);
`else
  assign bus.fetch_misalign = 1'b0;
`endif

`ifndef SYNTHESIS
  // Memory may only answer the single request the stage is waiting on.
  rvalid_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_rvalid |-> (state == ST_WAIT));
`endif

endmodule
